calc1_core: RTL and testbench
=============================

// Module: calc1_core
// PURPOSE
//  Four-port 32-bit integer calculator: add, subtract, shift left, shift right.
//  Each requester port 1..4 has a command/operand input and a response/result output.
//  Ports operate independently and concurrently.
//  Top of the calc1 hierarchy; a wrapper drives the pins directly.
// PARAMETERS
//  none (widths fixed: data 32, cmd 4, resp 2)
// PORTS
//  c_clk         in   1     functional clock, rising edge
//  reset         in   [1:7] async active-high; any bit 1 => whole block in reset
//  a_clk,b_clk   in   1     scan clocks, functionally ignored (one clock: c_clk)
//  scan_in       in   1     scan data in (see CONFIGURATION)
//  scan_out      out  1     scan data out
//  error_found   in   [0:3] reserved debug control, ignored
//  reqN_cmd_in   in   [0:3] N=1..4; command, bit 0 = MSB
//  reqN_data_in  in   [0:31] N=1..4; operand, bit 0 = MSB
//  out_respN     out  [0:1] N=1..4; response code
//  out_dataN     out  [0:31] N=1..4; result
// BEHAVIOUR
//  Command codes:
//    0 = nop
//    1 = add
//    2 = sub
//    5 = shl
//    6 = shr
//    all other values = invalid
//  Response codes:
//    0 = none
//    1 = success
//    2 = overflow/underflow
//    3 = invalid command
//  Reset (async, any reset bit high):
//    all out_resp*/out_data* = 0; all ports idle; pending ops discarded.
//    Reset mid-operation produces no response.
//  Issue: in cycle T, idle port samples cmd!=0 with reqN_data_in = op1.
//    Cycle T+1 samples reqN_data_in = op2 (cmd ignored in T+1).
//  Response: out_respN != 0 and out_dataN valid during cycle T+3, exactly one cycle.
//    Both outputs are 0 in every other cycle.
//  Busy: port is busy in cycles T+1..T+3; cmds sampled while busy are dropped silently.
//    Next command is accepted from cycle T+4.
//  add: unsigned op1+op2.
//    Carry out of bit 0 => resp 2, data 0.
//    Otherwise resp 1, data = 32-bit sum.
//  sub: unsigned op1-op2.
//    op2 > op1 => resp 2, data 0.
//    Otherwise resp 1, data = difference (equal operands => resp 1, data 0).
//  shl/shr: shift op1 by op2[27:31] (0..31) bit positions; op2[0:26] ignored.
//    Logical shift, vacated bits 0, bits shifted out lost.
//    Always resp 1; shift of 0 returns op1.
//  invalid cmd: still consumes the op2 cycle and respects latency; resp 3, data 0.
//  Ports share no state: simultaneous commands on all 4 ports all complete at T+3.
// CONFIGURATION
//  CALC1_SCAN_EN defined:
//    scan_out = scan_in registered on c_clk (1-cycle delay).
//    scan_out resets to 0.
//  CALC1_SCAN_EN undefined:
//    scan_out tied 0; scan_in ignored.
//  Calculation behaviour is identical in both builds.
// TESTING
//  Reset all bits 1 for 7 cycles, then release:
//    all out_resp*=0 and out_data*=0; no spurious responses for 10 cycles.
//  Port1 add 0x00000005+0x00000007:
//    resp 1, data 0x0000000C at T+3.
//  Port1 add 0xFFFFFFFF+1 -> resp 2, data 0.
//  Port1 sub 3-5 -> resp 2, data 0.
//  Port1 sub 5-5 -> resp 1, data 0.
//  Port2 shl 0x00000001 by 0x00000021 (low 5 bits = 1) -> resp 1, data 0x00000002.
//  Port2 shr 0x80000000 by 31 -> resp 1, data 1.
//  Port3 cmd 4 -> resp 3, data 0.
//  Port3 cmd 1 at T, then cmd 1 at T+2 (busy) -> single response at T+3, none later.
//  All 4 ports add in the same cycle -> 4 correct responses at T+3.
//  Reset asserted at T+2 -> no response from that command.

Source files
------------

// File: rtl/calc1_core_if.sv
// rtl/calc1_core_if.sv - per-port command/operand and response/result bundle for calc1_core
interface calc1_core_if;
  logic [0:3]  req_cmd  [1:4];
  logic [0:31] req_data [1:4];
  logic [0:1]  out_resp [1:4];
  logic [0:31] out_data [1:4];

  modport master (output req_cmd, output req_data, input out_resp, input out_data);
  modport slave  (input req_cmd, input req_data, output out_resp, output out_data);
endinterface

// File: rtl/calc1_core.sv
// rtl/calc1_core.sv - four independent 32-bit add/sub/shift ports, result 3 cycles after issue
// Optional scan flop on scan_in -> scan_out built when CALC1_SCAN_EN is defined.
module calc1_core (
  input  logic        c_clk,
  input  logic [1:7]  reset,
  input  logic        a_clk,
  input  logic        b_clk,
  input  logic        scan_in,
  output logic        scan_out,
  input  logic [0:3]  error_found,
  calc1_core_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_OP2, ST_EXEC, ST_RESP} port_state_t;

  localparam logic [0:3] CMD_NOP = 4'd0;
  localparam logic [0:3] CMD_ADD = 4'd1;
  localparam logic [0:3] CMD_SUB = 4'd2;
  localparam logic [0:3] CMD_SHL = 4'd5;
  localparam logic [0:3] CMD_SHR = 4'd6;

  localparam logic [0:1] RESP_NONE = 2'd0;
  localparam logic [0:1] RESP_OK   = 2'd1;
  localparam logic [0:1] RESP_OVF  = 2'd2;
  localparam logic [0:1] RESP_INV  = 2'd3;

  logic rst;
  logic unused_inputs;

  port_state_t state  [1:4];
  logic [0:3]  cmd_q  [1:4];
  logic [0:31] op1_q  [1:4];
  logic [0:31] op2_q  [1:4];
  logic [0:1]  resp_q [1:4];
  logic [0:31] data_q [1:4];

  assign rst = |reset;

  // Returns {resp, data}; bit 0 of op vectors is the MSB, so op2[27:31] is the 5-bit shift count.
  function automatic logic [33:0] calc(input logic [0:3] cmd, input logic [0:31] op1,
                                       input logic [0:31] op2);
    logic [32:0] sum;
    logic [4:0]  sh;
    sum = {1'b0, op1} + {1'b0, op2};
    sh  = op2[27:31];
    case (cmd)
      CMD_ADD: return sum[32] ? {RESP_OVF, 32'h0} : {RESP_OK, sum[31:0]};
      CMD_SUB: return (op2 > op1) ? {RESP_OVF, 32'h0} : {RESP_OK, op1 - op2};
      CMD_SHL: return {RESP_OK, op1 << sh};
      CMD_SHR: return {RESP_OK, op1 >> sh};
      default: return {RESP_INV, 32'h0};
    endcase
  endfunction

  // Each port: IDLE (T) -> OP2 (T+1) -> EXEC (T+2) -> RESP (T+3, outputs valid) -> IDLE.
  always_ff @(posedge c_clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= 4; i++) begin
        state[i]  <= ST_IDLE;
        cmd_q[i]  <= CMD_NOP;
        op1_q[i]  <= 32'h0;
        op2_q[i]  <= 32'h0;
        resp_q[i] <= RESP_NONE;
        data_q[i] <= 32'h0;
      end
    end else begin
      for (int i = 1; i <= 4; i++) begin
        case (state[i])
          ST_IDLE: begin
            if (bus.req_cmd[i] != CMD_NOP) begin
              cmd_q[i] <= bus.req_cmd[i];
              op1_q[i] <= bus.req_data[i];
              state[i] <= ST_OP2;
            end
          end
          ST_OP2: begin
            op2_q[i] <= bus.req_data[i];
            state[i] <= ST_EXEC;
          end
          ST_EXEC: begin
            {resp_q[i], data_q[i]} <= calc(cmd_q[i], op1_q[i], op2_q[i]);
            state[i] <= ST_RESP;
          end
          ST_RESP: begin
            resp_q[i] <= RESP_NONE;
            data_q[i] <= 32'h0;
            state[i]  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.out_resp = resp_q;
  assign bus.out_data = data_q;

`ifdef CALC1_SCAN_EN
  always_ff @(posedge c_clk or posedge rst) begin
    if (rst) begin
      scan_out <= 1'b0;
    end else begin
      scan_out <= scan_in;
    end
  end
  assign unused_inputs = ^{a_clk, b_clk, error_found};
`else
  assign scan_out      = 1'b0;
  assign unused_inputs = ^{a_clk, b_clk, error_found, scan_in};
`endif

endmodule

// File: tb/tb_calc1_core.sv
// tb/tb_calc1_core.sv - directed vectors for calc1_core checked against a cycle-level reference model
module tb_calc1_core;

  logic        c_clk = 1'b0;
  logic [1:7]  reset;
  logic        a_clk;
  logic        b_clk;
  logic        scan_in;
  logic        scan_out;
  logic [0:3]  error_found;

  calc1_core_if bus ();

  calc1_core dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .a_clk       (a_clk),
    .b_clk       (b_clk),
    .scan_in     (scan_in),
    .scan_out    (scan_out),
    .error_found (error_found),
    .bus         (bus)
  );

  always #5 c_clk = ~c_clk;

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  int          exp_at     [1:4];
  logic [1:0]  exp_r      [1:4];
  logic [31:0] exp_d      [1:4];
  int          busy_until [1:4];
  logic [31:0] op2_next   [1:4];
  bit          has_op2    [1:4];
  logic        scan_model = 1'b0;

  typedef struct {
    int          p;
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  r;
    logic [31:0] d;
  } vec_t;

  vec_t vecs [14];

  always @(posedge c_clk) begin
    cyc <= cyc + 1;
    scan_model <= scan_in;
  end

  // Reference arithmetic straight from the command definitions.
  function automatic logic [33:0] model(input int cmd, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] s;
    case (cmd)
      1: begin
        s = 64'(a) + 64'(b);
        if (s > 64'hFFFF_FFFF) return {2'd2, 32'd0};
        return {2'd1, s[31:0]};
      end
      2: begin
        if (b > a) return {2'd2, 32'd0};
        return {2'd1, a - b};
      end
      5: return {2'd1, a << (b % 32)};
      6: return {2'd1, a >> (b % 32)};
      default: return {2'd3, 32'd0};
    endcase
  endfunction

  task automatic model_reset();
    for (int p = 1; p <= 4; p++) begin
      exp_at[p]     = -1;
      busy_until[p] = 0;
      has_op2[p]    = 1'b0;
    end
  endtask

  task automatic post(input int p, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    bus.req_cmd[p]  = cmd;
    bus.req_data[p] = a;
    if (cmd != 4'd0 && cyc >= busy_until[p]) begin
      {exp_r[p], exp_d[p]} = model(int'(cmd), a, b);
      exp_at[p]     = cyc + 3;
      busy_until[p] = cyc + 4;
      op2_next[p]   = b;
      has_op2[p]    = 1'b1;
    end
  endtask

  // Op2 cycle carries a junk command that the port must ignore.
  task automatic tick();
    @(posedge c_clk);
    #1;
    for (int p = 1; p <= 4; p++) begin
      if (has_op2[p]) begin
        bus.req_cmd[p]  = 4'hF;
        bus.req_data[p] = op2_next[p];
        has_op2[p]      = 1'b0;
      end else begin
        bus.req_cmd[p]  = 4'd0;
        bus.req_data[p] = $urandom;
      end
    end
    scan_in = ($urandom & 1) != 0;
  endtask

  task automatic lit(input int p, input logic [1:0] r, input logic [31:0] d, input string name);
    compared++;
    if (bus.out_resp[p] !== r || bus.out_data[p] !== d) begin
      mismatched++;
      $display("FAIL %s port%0d: got resp %0d data %h, want resp %0d data %h",
               name, p, bus.out_resp[p], bus.out_data[p], r, d);
    end
  endtask

  always @(negedge c_clk) begin
    logic [1:0]  er;
    logic [31:0] ed;
    logic        es;
    for (int p = 1; p <= 4; p++) begin
      er = (exp_at[p] == cyc) ? exp_r[p] : 2'd0;
      ed = (exp_at[p] == cyc) ? exp_d[p] : 32'd0;
      compared++;
      if (bus.out_resp[p] !== er || bus.out_data[p] !== ed) begin
        mismatched++;
        $display("FAIL model port%0d cyc %0d: got resp %0d data %h, want resp %0d data %h",
                 p, cyc, bus.out_resp[p], bus.out_data[p], er, ed);
      end
    end
`ifdef CALC1_SCAN_EN
    es = (|reset) ? 1'b0 : scan_model;
`else
    es = 1'b0;
`endif
    compared++;
    if (scan_out !== es) begin
      mismatched++;
      $display("FAIL scan_out cyc %0d: got %0b want %0b", cyc, scan_out, es);
    end
  end

  initial begin
    reset       = '1;
    a_clk       = 1'b0;
    b_clk       = 1'b0;
    scan_in     = 1'b0;
    error_found = 4'h0;
    for (int p = 1; p <= 4; p++) begin
      bus.req_cmd[p]  = 4'd0;
      bus.req_data[p] = 32'd0;
    end
    model_reset();

    vecs[0]  = '{1, 4'd1, 32'h0000_0005, 32'h0000_0007, 2'd1, 32'h0000_000C};
    vecs[1]  = '{1, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000};
    vecs[2]  = '{1, 4'd2, 32'h0000_0003, 32'h0000_0005, 2'd2, 32'h0000_0000};
    vecs[3]  = '{1, 4'd2, 32'h0000_0005, 32'h0000_0005, 2'd1, 32'h0000_0000};
    vecs[4]  = '{1, 4'd2, 32'h0000_0009, 32'h0000_0004, 2'd1, 32'h0000_0005};
    vecs[5]  = '{2, 4'd5, 32'h0000_0001, 32'h0000_0021, 2'd1, 32'h0000_0002};
    vecs[6]  = '{2, 4'd6, 32'h8000_0000, 32'h0000_001F, 2'd1, 32'h0000_0001};
    vecs[7]  = '{2, 4'd5, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 2'd1, 32'hDEAD_BEEF};
    vecs[8]  = '{2, 4'd6, 32'hF000_0000, 32'h0000_0004, 2'd1, 32'h0F00_0000};
    vecs[9]  = '{3, 4'd4, 32'h0000_0000, 32'h0000_0000, 2'd3, 32'h0000_0000};
    vecs[10] = '{3, 4'd15, 32'h0000_0001, 32'h0000_0002, 2'd3, 32'h0000_0000};
    vecs[11] = '{4, 4'd1, 32'h7FFF_FFFF, 32'h8000_0000, 2'd1, 32'hFFFF_FFFF};
    vecs[12] = '{4, 4'd1, 32'h8000_0000, 32'h8000_0000, 2'd2, 32'h0000_0000};
    vecs[13] = '{4, 4'd5, 32'h8000_0001, 32'h0000_0001, 2'd1, 32'h0000_0002};

    repeat (7) tick();
    reset = '0;
    for (int p = 1; p <= 4; p++) lit(p, 2'd0, 32'd0, "reset_clear");
    repeat (10) tick();

    // Each next vector issues exactly at T+4 of the previous one on the same port.
    foreach (vecs[i]) begin
      post(vecs[i].p, vecs[i].cmd, vecs[i].a, vecs[i].b);
      repeat (3) tick();
      lit(vecs[i].p, vecs[i].r, vecs[i].d, "vector");
      tick();
    end

    post(3, 4'd1, 32'd10, 32'd20);
    tick();
    tick();
    post(3, 4'd1, 32'd1, 32'd1);
    tick();
    lit(3, 2'd1, 32'd30, "busy_first");
    repeat (6) tick();

    for (int p = 1; p <= 4; p++) post(p, 4'd1, 32'(p * 100), 32'(p));
    repeat (3) tick();
    for (int p = 1; p <= 4; p++) lit(p, 2'd1, 32'(p * 101), "all_ports");
    tick();

    post(1, 4'd1, 32'd1, 32'd1);
    tick();
    tick();
    reset[4] = 1'b1;
    model_reset();
    tick();
    lit(1, 2'd0, 32'd0, "reset_midop");
    tick();
    reset = '0;
    repeat (5) tick();

    post(1, 4'd2, 32'd10, 32'd3);
    repeat (3) tick();
    lit(1, 2'd1, 32'd7, "after_reset");
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
